tree_node_arbiter: RTL and testbench



---
 rtl/tree_node_arbiter.sv | 154 +++++++++++++++
 tb/tb_tree_node_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tree_node_arbiter.sv
// Tree node: NUM_CH child FIFOs merged round-robin into one registered, channel-tagged stream.
// Optional per-channel input counters are enabled with `define TREE_NODE_STATS_EN.
module tree_node_arbiter #(
    parameter int NUM_CH     = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     busy,
    input  logic [CH_W-1:0]          stat_sel,
    output logic [15:0]              stat_cnt
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    logic [DATA_W-1:0] mem_q  [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q [NUM_CH];
    logic [PTR_W-1:0]  rptr_q [NUM_CH];

    logic [NUM_CH-1:0] empty, full, push, pop;
    logic              load_en;
    logic              gnt_found;
    logic [CH_W-1:0]   gnt_idx;
    int                idx;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic              busy_q, busy_d;

    // Pointer MSB distinguishes full from empty when the index bits match.
    always_comb begin
        empty = '0;
        full  = '0;
        push  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            empty[i] = (wptr_q[i] == rptr_q[i]);
            full[i]  = (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]) &&
                       (wptr_q[i][AW] != rptr_q[i][AW]);
            push[i]  = in_valid[i] && !full[i];
        end
    end

    assign in_ready = ~full;
    assign load_en  = !out_valid_q || out_ready;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_found && !empty[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        pop          = '0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        last_grant_d = last_grant_q;
        busy_d       = (~empty != '0) || out_valid_q;
        if (load_en) begin
            if (gnt_found) begin
                pop[gnt_idx] = 1'b1;
                out_valid_d  = 1'b1;
                out_data_d   = mem_q[gnt_idx][rptr_q[gnt_idx][AW-1:0]];
                out_ch_d     = gnt_idx;
                last_grant_d = gnt_idx;
            end else begin
                out_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) mem_q[i][wptr_q[i][AW-1:0]] <= in_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            busy_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wptr_q[i] <= wptr_q[i] + PTR_W'(1);
                if (pop[i])  rptr_q[i] <= rptr_q[i] + PTR_W'(1);
            end
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign busy      = busy_q;

`ifdef TREE_NODE_STATS_EN
    logic [15:0] cnt_q [NUM_CH];

    // Accepted-word counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(stat_sel) == i) stat_cnt = cnt_q[i];
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_tree_node_arbiter.sv
// Directed bench for tree_node_arbiter with NUM_CH=5, DATA_W=32, FIFO_DEPTH=4.
module tb_tree_node_arbiter;

    localparam int NUM_CH = 5;
    localparam int DATA_W = 32;
    localparam int CH_W   = 3;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_CH-1:0]        in_valid = '0;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     busy;
    logic [CH_W-1:0]          stat_sel = '0;
    logic [15:0]              stat_cnt;

    int total = 0;
    int bad   = 0;

    tree_node_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .busy(busy), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        total++; if (in_ready !== 5'h1F) begin bad++; $display("FAIL rst_in_ready got=%h exp=%h", in_ready, 5'h1F); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        total++; if (out_ch !== 3'd0) begin bad++; $display("FAIL rst_out_ch got=%0d exp=0", out_ch); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (stat_cnt !== 16'h0) begin bad++; $display("FAIL rst_stat_cnt got=%h exp=0", stat_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_single_word;
        do_reset();
        out_ready = 1'b1;
        in_valid = 5'b00100;
        in_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
        tick();
        in_valid = '0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sw_t1_valid got=%b exp=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sw_t2_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_t2_data got=%h exp=deadbeef", out_data); end
        total++; if (out_ch !== 3'd2) begin bad++; $display("FAIL sw_t2_ch got=%0d exp=2", out_ch); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL sw_t2_busy got=%b exp=1", busy); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sw_t3_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_fairness;
        logic [CH_W-1:0]   exp_ch;
        logic [DATA_W-1:0] exp_data;
        do_reset();
        for (int w = 0; w < 2; w++) begin
            in_valid = 5'h1F;
            for (int c = 0; c < NUM_CH; c++) in_data[c*DATA_W +: DATA_W] = 32'hA0000000 + c * 16 + w;
            tick();
        end
        in_valid = '0;
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            exp_ch   = CH_W'(n % NUM_CH);
            exp_data = 32'hA0000000 + (n % NUM_CH) * 16 + (n / NUM_CH);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fair_valid[%0d] got=%b exp=1", n, out_valid); end
            total++; if (out_ch !== exp_ch || out_data !== exp_data) begin
                bad++; $display("FAIL fair_word[%0d] got ch=%0d data=%h exp ch=%0d data=%h", n, out_ch, out_data, exp_ch, exp_data);
            end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fair_end_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure;
        do_reset();
        in_valid = 5'b00110;
        in_data[1*DATA_W +: DATA_W] = 32'h11110001;
        in_data[2*DATA_W +: DATA_W] = 32'h22220002;
        tick();
        in_valid = '0;
        tick();
        for (int n = 0; n < 5; n++) begin
            total++; if (out_valid !== 1'b1 || out_ch !== 3'd1 || out_data !== 32'h11110001) begin
                bad++; $display("FAIL bp_hold[%0d] got v=%b ch=%0d data=%h exp v=1 ch=1 data=11110001", n, out_valid, out_ch, out_data);
            end
            total++; if (in_ready !== 5'h1F) begin bad++; $display("FAIL bp_in_ready[%0d] got=%h exp=1f", n, in_ready); end
            if (n == 4) out_ready = 1'b1;
            tick();
        end
        total++; if (out_valid !== 1'b1 || out_ch !== 3'd2 || out_data !== 32'h22220002) begin
            bad++; $display("FAIL bp_release got v=%b ch=%0d data=%h exp v=1 ch=2 data=22220002", out_valid, out_ch, out_data);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_full;
        do_reset();
        for (int w = 1; w <= 5; w++) begin
            total++; if (in_ready[3] !== 1'b1) begin bad++; $display("FAIL full_ready_before[%0d] got=%b exp=1", w, in_ready[3]); end
            in_valid = 5'b01000;
            in_data[3*DATA_W +: DATA_W] = 32'h33330000 + w;
            tick();
        end
        in_valid = '0;
        total++; if (in_ready[3] !== 1'b0) begin bad++; $display("FAIL full_ready_full got=%b exp=0", in_ready[3]); end
        total++; if (out_data !== 32'h33330001) begin bad++; $display("FAIL full_head got=%h exp=33330001", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (in_ready[3] !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop got=%b exp=1", in_ready[3]); end
        out_ready = 1'b1;
        for (int w = 2; w <= 5; w++) begin
            total++; if (out_valid !== 1'b1 || out_ch !== 3'd3 || out_data !== 32'h33330000 + w) begin
                bad++; $display("FAIL full_order[%0d] got v=%b ch=%0d data=%h exp v=1 ch=3 data=%h", w, out_valid, out_ch, out_data, 32'h33330000 + w);
            end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_end_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        in_valid = 5'b00111;
        for (int c = 0; c < 3; c++) in_data[c*DATA_W +: DATA_W] = 32'h50500000 + c;
        tick();
        in_valid = '0;
        tick();
        total++; if (out_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rm_pre got v=%b busy=%b exp v=1 busy=1", out_valid, busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 5'h1F) begin bad++; $display("FAIL rm_in_ready got=%h exp=1f", in_ready); end
        out_ready = 1'b1;
        in_valid = 5'b10000;
        in_data[4*DATA_W +: DATA_W] = 32'h44440004;
        tick();
        in_valid = '0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_t1_valid got=%b exp=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1 || out_ch !== 3'd4 || out_data !== 32'h44440004) begin
            bad++; $display("FAIL rm_t2 got v=%b ch=%0d data=%h exp v=1 ch=4 data=44440004", out_valid, out_ch, out_data);
        end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_no_replay got=%b exp=0", out_valid); end
    endtask

    task automatic test_stats;
        int accepted;
        int cycles;
        logic was_ready;
        do_reset();
        out_ready = 1'b1;
        stat_sel = 3'd0;
`ifdef TREE_NODE_STATS_EN
        accepted = 0;
        cycles = 0;
        while (accepted < 70000 && cycles < 80000) begin
            in_valid = 5'b00001;
            in_data[0 +: DATA_W] = 32'(accepted);
            was_ready = in_ready[0];
            tick();
            cycles++;
            if (was_ready) begin
                accepted++;
                if (accepted == 10) begin
                    total++; if (stat_cnt !== 16'd10) begin bad++; $display("FAIL stat_cnt10 got=%0d exp=10", stat_cnt); end
                end
            end
        end
        in_valid = '0;
        total++; if (accepted != 70000) begin bad++; $display("FAIL stat_push_budget got=%0d exp=70000", accepted); end
        total++; if (stat_cnt !== 16'hFFFF) begin bad++; $display("FAIL stat_sat got=%h exp=ffff", stat_cnt); end
        stat_sel = 3'd1;
        #1;
        total++; if (stat_cnt !== 16'h0) begin bad++; $display("FAIL stat_ch1 got=%h exp=0", stat_cnt); end
        stat_sel = 3'd5;
        #1;
        total++; if (stat_cnt !== 16'h0) begin bad++; $display("FAIL stat_oob got=%h exp=0", stat_cnt); end
`else
        accepted = 0;
        cycles = 0;
        was_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            in_valid = 5'b00001;
            in_data[0 +: DATA_W] = 32'(n);
            tick();
            total++; if (stat_cnt !== 16'h0) begin bad++; $display("FAIL stat_off[%0d] got=%h exp=0", n, stat_cnt); end
        end
        in_valid = '0;
        stat_sel = 3'd1;
        #1;
        total++; if (stat_cnt !== 16'h0) begin bad++; $display("FAIL stat_off_ch1 got=%h exp=0", stat_cnt); end
`endif
        for (int n = 0; n < 8; n++) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stat_drain got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fairness();
        test_backpressure();
        test_full();
        test_reset_mid();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
